// File: rtl/jtag_ir_dr_datapath.sv
// rtl/jtag_ir_dr_datapath.sv - JTAG IR plus BYPASS/IDCODE/USER data register datapath
module jtag_ir_dr_datapath #(
  parameter int                      IR_WIDTH     = 4,
  parameter int                      USER_WIDTH   = 8,
  parameter logic [31:0]             IDCODE_VAL   = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0]     INSTR_IDCODE = 4'b0001,
  parameter logic [IR_WIDTH-1:0]     INSTR_USER   = 4'b0010
) (
  input  logic                  clk,
  input  logic                  TRST,
  input  logic [3:0]            tap_state,
  input  logic                  TDI,
  output logic                  TDO,
  output logic                  TDO_en,
  output logic [IR_WIDTH-1:0]   ir_out,
  input  logic [USER_WIDTH-1:0] user_dr_in,
  output logic [USER_WIDTH-1:0] user_dr_out,
  output logic                  update_pulse
);

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,  RUN_TEST_IDLE = 4'd1,  SELECT_DR = 4'd2,  CAPTURE_DR = 4'd3,
    SHIFT_DR         = 4'd4,  EXIT1_DR      = 4'd5,  PAUSE_DR  = 4'd6,  EXIT2_DR   = 4'd7,
    UPDATE_DR        = 4'd8,  SELECT_IR     = 4'd9,  CAPTURE_IR = 4'd10, SHIFT_IR  = 4'd11,
    EXIT1_IR         = 4'd12, PAUSE_IR      = 4'd13, EXIT2_IR  = 4'd14, UPDATE_IR  = 4'd15
  } tap_state_e;

  tap_state_e            w_state;
  logic                  w_sel_idcode;
  logic                  w_sel_user;
  logic [IR_WIDTH-1:0]   r_ir_shift;
  logic [IR_WIDTH-1:0]   r_ir_out;
  logic                  r_bypass;
  logic [31:0]           r_idcode_sr;
  logic [USER_WIDTH-1:0] r_user_sr;
  logic [USER_WIDTH-1:0] r_user_dr_out;
  logic                  r_update_pulse;

  assign w_state      = tap_state_e'(tap_state);
  assign w_sel_idcode = (r_ir_out == INSTR_IDCODE);
  assign w_sel_user   = (r_ir_out == INSTR_USER);

  always_ff @(posedge clk) begin
    r_update_pulse <= 1'b0;
    if (TRST || w_state == TEST_LOGIC_RESET) begin
      r_ir_out    <= INSTR_IDCODE;
      r_ir_shift  <= '0;
      r_bypass    <= 1'b0;
      r_idcode_sr <= '0;
      r_user_sr   <= '0;
      // Test-Logic-Reset without TRST keeps the last value handed to core logic
      if (TRST) r_user_dr_out <= '0;
    end else begin
      case (w_state)
        CAPTURE_IR: r_ir_shift <= IR_WIDTH'(2'b01);
        SHIFT_IR:   r_ir_shift <= {TDI, r_ir_shift[IR_WIDTH-1:1]};
        UPDATE_IR:  r_ir_out   <= r_ir_shift;
        CAPTURE_DR: begin
          if (w_sel_idcode)    r_idcode_sr <= IDCODE_VAL;
          else if (w_sel_user) r_user_sr   <= user_dr_in;
          else                 r_bypass    <= 1'b0;
        end
        SHIFT_DR: begin
          // shift-and-or form keeps USER_WIDTH=1 legal
          if (w_sel_idcode)    r_idcode_sr <= {TDI, r_idcode_sr[31:1]};
          else if (w_sel_user) r_user_sr   <= (r_user_sr >> 1) | (USER_WIDTH'(TDI) << (USER_WIDTH-1));
          else                 r_bypass    <= TDI;
        end
        UPDATE_DR: begin
          if (w_sel_user) begin
            r_user_dr_out  <= r_user_sr;
            r_update_pulse <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    TDO    = 1'b0;
    TDO_en = 1'b0;
    case (w_state)
      SHIFT_IR: begin
        TDO    = r_ir_shift[0];
        TDO_en = 1'b1;
      end
      SHIFT_DR: begin
        TDO_en = 1'b1;
        if (w_sel_idcode)    TDO = r_idcode_sr[0];
        else if (w_sel_user) TDO = r_user_sr[0];
        else                 TDO = r_bypass;
      end
      default: ;
    endcase
  end

  assign ir_out       = r_ir_out;
  assign user_dr_out  = r_user_dr_out;
  assign update_pulse = r_update_pulse;

endmodule

// File: tb/tb_jtag_ir_dr_datapath.sv
// tb/tb_jtag_ir_dr_datapath.sv - directed bench for jtag_ir_dr_datapath
module tb_jtag_ir_dr_datapath;

  logic       clk;
  logic       TRST;
  logic [3:0] tap_state;
  logic       TDI;
  logic       TDO;
  logic       TDO_en;
  logic [3:0] ir_out;
  logic [7:0] user_dr_in;
  logic [7:0] user_dr_out;
  logic       update_pulse;

  int checks   = 0;
  int failures = 0;

  jtag_ir_dr_datapath dut (
    .clk          (clk),
    .TRST         (TRST),
    .tap_state    (tap_state),
    .TDI          (TDI),
    .TDO          (TDO),
    .TDO_en       (TDO_en),
    .ir_out       (ir_out),
    .user_dr_in   (user_dr_in),
    .user_dr_out  (user_dr_out),
    .update_pulse (update_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic [3:0] st, input logic tdi);
    tap_state = st;
    TDI       = tdi;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] code);
    set(4'd10, 1'b0); step;
    for (int i = 0; i < 4; i++) begin
      set(4'd11, code[i]); step;
    end
    set(4'd12, 1'b0); step;
    set(4'd15, 1'b0); step;
    set(4'd1, 1'b0); step;
  endtask

  task automatic read_idcode(input string tag);
    logic [31:0] idv;
    idv = 32'h1000_0001;
    set(4'd3, 1'b0); step;
    for (int i = 0; i < 32; i++) begin
      set(4'd4, 1'b0);
      chk({tag, "_tdo"}, {31'd0, TDO}, {31'd0, idv[i]});
      chk({tag, "_en"}, {31'd0, TDO_en}, 32'd1);
      step;
    end
    set(4'd1, 1'b0); step;
  endtask

  initial begin
    logic [7:0] pat_in;
    logic [7:0] pat_out;
    logic [2:0] byp_in;
    logic [2:0] byp_out;

    TRST = 1'b1; tap_state = 4'd0; TDI = 1'b0; user_dr_in = 8'h00;
    step; step;
    chk("rst_ir", {28'd0, ir_out}, 32'h1);
    chk("rst_user", {24'd0, user_dr_out}, 32'h0);
    chk("rst_pulse", {31'd0, update_pulse}, 32'h0);
    chk("rst_en", {31'd0, TDO_en}, 32'h0);
    TRST = 1'b0;
    set(4'd1, 1'b0);
    chk("idle_tdo", {31'd0, TDO}, 32'h0);
    chk("idle_en", {31'd0, TDO_en}, 32'h0);
    step;

    read_idcode("idcode");

    // IR load with all-ones: captured pattern 0001 leaves LSB first
    set(4'd10, 1'b0); step;
    for (int i = 0; i < 4; i++) begin
      set(4'd11, 1'b1);
      chk("irshift_tdo", {31'd0, TDO}, (i == 0) ? 32'd1 : 32'd0);
      chk("irshift_en", {31'd0, TDO_en}, 32'd1);
      step;
    end
    set(4'd12, 1'b0); step;
    set(4'd15, 1'b0); step;
    chk("ir_ones", {28'd0, ir_out}, 32'hF);

    byp_in = 3'b101; byp_out = 3'b010;
    set(4'd3, 1'b0); step;
    for (int i = 0; i < 3; i++) begin
      set(4'd4, byp_in[i]);
      chk("bypass_tdo", {31'd0, TDO}, {31'd0, byp_out[i]});
      step;
    end
    set(4'd1, 1'b0); step;

    load_ir(4'h2);
    chk("ir_user", {28'd0, ir_out}, 32'h2);
    user_dr_in = 8'hA5;
    pat_in = 8'h3C; pat_out = 8'hA5;
    set(4'd3, 1'b0); step;
    for (int i = 0; i < 8; i++) begin
      set(4'd4, pat_in[i]);
      chk("user_tdo", {31'd0, TDO}, {31'd0, pat_out[i]});
      step;
    end
    set(4'd5, 1'b0); step;
    chk("user_pre_upd", {31'd0, update_pulse}, 32'h0);
    set(4'd8, 1'b0); step;
    chk("user_out", {24'd0, user_dr_out}, 32'h3C);
    chk("user_pulse", {31'd0, update_pulse}, 32'h1);
    set(4'd1, 1'b0); step;
    chk("user_pulse_off", {31'd0, update_pulse}, 32'h0);
    chk("user_hold", {24'd0, user_dr_out}, 32'h3C);

    load_ir(4'h5);
    chk("ir_unknown", {28'd0, ir_out}, 32'h5);
    byp_in = 3'b011; byp_out = 3'b110;
    set(4'd3, 1'b0); step;
    for (int i = 0; i < 3; i++) begin
      set(4'd4, byp_in[i]);
      chk("unk_tdo", {31'd0, TDO}, {31'd0, byp_out[i]});
      step;
    end
    set(4'd5, 1'b0); step;
    set(4'd8, 1'b0); step;
    chk("unk_pulse", {31'd0, update_pulse}, 32'h0);
    chk("unk_user", {24'd0, user_dr_out}, 32'h3C);
    set(4'd1, 1'b0); step;

    // TRST lands on the third Shift-IR edge; without it ir_shift would be 1110
    set(4'd10, 1'b0); step;
    set(4'd11, 1'b1); step;
    set(4'd11, 1'b1); step;
    TRST = 1'b1;
    set(4'd11, 1'b1); step;
    TRST = 1'b0;
    chk("midrst_ir", {28'd0, ir_out}, 32'h1);
    chk("midrst_user", {24'd0, user_dr_out}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      set(4'd11, 1'b0);
      chk("midrst_shift", {31'd0, TDO}, 32'h0);
      step;
    end
    set(4'd1, 1'b0);
    chk("midrst_idle_tdo", {31'd0, TDO}, 32'h0);
    step;
    read_idcode("post_rst_idcode");

    // Test-Logic-Reset without TRST: IR reverts, user_dr_out survives
    load_ir(4'h2);
    set(4'd3, 1'b0); step;
    for (int i = 0; i < 8; i++) begin
      set(4'd4, pat_out[i]); step;
    end
    set(4'd8, 1'b0); step;
    chk("tlr_pre_user", {24'd0, user_dr_out}, 32'hA5);
    chk("tlr_pre_ir", {28'd0, ir_out}, 32'h2);
    set(4'd0, 1'b0); step;
    chk("tlr_ir", {28'd0, ir_out}, 32'h1);
    chk("tlr_user", {24'd0, user_dr_out}, 32'hA5);
    chk("tlr_pulse", {31'd0, update_pulse}, 32'h0);
    set(4'd1, 1'b0); step;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_ir_dr_datapath.md
Name: jtag_ir_dr_datapath

Overview:
JTAG instruction/data register datapath, directly downstream of the TAP state machine. It consumes the 4-bit TAP state code each TCK cycle. It implements the instruction register (IR) and three data registers: BYPASS, IDCODE and an 8-bit USER register. It drives TDO serially, and presents the decoded instruction plus the USER update value to core logic.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
USER_WIDTH, 8, USER data register width (>=1)
IDCODE_VAL, 32'h1000_0001, value captured into IDCODE DR; bit0 must be 1
INSTR_IDCODE, 4'b0001, IR code selecting IDCODE (also IR reset value)
INSTR_USER, 4'b0010, IR code selecting USER DR

Ports:
clk  in  1  TCK; all state changes on rising edge
TRST  in  1  synchronous active-high reset
tap_state  in  4  current TAP state code, sampled at each rising clk
TDI  in  1  serial test data in
TDO  out  1  serial test data out
TDO_en  out  1  high while shifting
ir_out  out  IR_WIDTH  active (updated) instruction
user_dr_in  in  USER_WIDTH  parallel value captured into USER DR
user_dr_out  out  USER_WIDTH  USER DR update register
update_pulse  out  1  one-cycle strobe when user_dr_out is written

Behaviour:
- TAP state codes: 0 Test-Logic-Reset, 1 Run-Test/Idle, 2 Select-DR, 3 Capture-DR, 4 Shift-DR, 5 Exit1-DR, 6 Pause-DR, 7 Exit2-DR, 8 Update-DR, 9 Select-IR, 10 Capture-IR, 11 Shift-IR, 12 Exit1-IR, 13 Pause-IR, 14 Exit2-IR, 15 Update-IR.
- Reset (TRST=1 at clk edge, highest priority):
  - ir_out=INSTR_IDCODE; ir_shift=0; bypass=0; idcode_sr=0; user_sr=0.
  - user_dr_out=0; update_pulse=0.
- tap_state=0 with TRST=0: same as reset, except user_dr_out holds its value.
- DR select, from ir_out: IDCODE if ir_out==INSTR_IDCODE; USER if ir_out==INSTR_USER; BYPASS for every other code, including all-ones.
- Capture-IR (10): ir_shift <= {zeros, 2'b01}, so LSB=1 and bit1=0.
- Shift-IR (11): ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]}, shifting right with TDI into the MSB.
- Update-IR (15): ir_out <= ir_shift. New DR selection takes effect from the next cycle.
- Capture-DR (3): only the selected DR loads:
  - bypass <= 0;
  - idcode_sr <= IDCODE_VAL;
  - user_sr <= user_dr_in.
- Shift-DR (4): the selected DR shifts right with TDI into its MSB. BYPASS is a 1-bit register: bypass <= TDI.
- Update-DR (8) with USER selected: user_dr_out <= user_sr, and update_pulse=1 for that cycle (registered, visible the cycle after the edge). In all other cases update_pulse=0.
- Exit1/Pause/Exit2/Select/Run-Test-Idle: all shift registers hold.
- TDO / TDO_en: combinational from the current tap_state and registers.
  - Shift-IR: TDO=ir_shift[0].
  - Shift-DR: TDO = LSB of the selected DR.
  - Otherwise TDO=0.
  - TDO_en=1 exactly in states 4 and 11.
- Latency:
  - A TDI bit presented in shift cycle n reaches TDO after N shift cycles (N = register length). BYPASS delay is 1 cycle.
  - The first TDO bit of a shift is the captured LSB.
- Shift-IR/Shift-DR entered without a preceding capture: the register shifts its current contents; no error.
- Reset mid-shift: registers clear on that edge. ir_out returns to INSTR_IDCODE; TDO=0 once tap_state leaves the shift states.
- An unknown tap_state is impossible with 4 bits; the default branch holds all registers.

Test Plan:
- Reset: assert TRST 2 cycles -> ir_out=4'b0001, user_dr_out=0, update_pulse=0, TDO_en=0.
- IDCODE read: after reset, sequence states 3, then 4 for 32 cycles, with TDI=0 -> TDO emits 0x10000001 LSB first (1,0,0,...,0,1 at bit 28). TDO_en=1 for all 32 cycles.
- IR load to BYPASS:
  - States 10, then 11 x4 with TDI=1,1,1,1, then 12, 15 -> TDO during shift = 1,0,0,0 and ir_out=4'hF.
  - Then states 3, 4 x3 with TDI=1,0,1 -> TDO=0,1,0.
- USER access:
  - Load IR=4'h2, set user_dr_in=8'hA5.
  - States 3, then 4 x8 with TDI=0x3C LSB first -> TDO=0xA5 LSB first (1,0,1,0,0,1,0,1).
  - Then 5, 8 -> user_dr_out=8'h3C, update_pulse high exactly one cycle.
- Unknown instruction: IR=4'h5 -> DR path behaves as BYPASS (1-cycle TDI->TDO); Update-DR leaves user_dr_out unchanged, update_pulse=0.
- Mid-operation reset:
  - TRST=1 during the 3rd Shift-IR cycle -> ir_out=4'b0001 next cycle and ir_shift cleared.
  - A subsequent Capture-DR/Shift-DR returns IDCODE_VAL.
  - Test-Logic-Reset (state 0) without TRST gives the same IR result while user_dr_out is preserved.
